// File: rtl/bird_pkg.sv
// Shared types, widths and geometry helpers for the multi-bird physics engine.
package bird_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAYING,
        ST_FALLING,
        ST_DEAD
    } bird_state_t;

    localparam int Y_W       = 10;
    localparam int POS_INT_W = 10;
    localparam int VEL_INT_W = 8;
    localparam int SUM_INT_W = 12;

    function automatic int pos_w(input int frac);
        return POS_INT_W + frac;
    endfunction

    function automatic int vel_w(input int frac);
        return VEL_INT_W + frac;
    endfunction

    function automatic int sum_w(input int frac);
        return SUM_INT_W + frac;
    endfunction

    function automatic int floor_px(input int y_min, input int active_height,
                                    input int ground_h, input int sprite_h);
        return y_min + active_height - ground_h - sprite_h;
    endfunction

endpackage

// File: rtl/bird_channel.sv
// One bird: flap edge latch, life-cycle FSM and fixed-point position/velocity update.
module bird_channel
    import bird_pkg::*;
#(
    parameter int FRAC       = 4,
    parameter int GRAVITY    = 16,
    parameter int FLAP_POWER = -112,
    parameter int MAX_FALL   = 64,
    parameter int CEIL_KILLS = 0,
    parameter int CEIL_PX    = 0,
    parameter int FLOOR_PX   = 456,
    parameter int START_PX   = 200
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_tick,
    input  logic             i_flap_btn,
    input  logic             i_collision,
    output logic [Y_W-1:0]   o_y,
    output bird_state_t      o_state
);

    localparam int POS_W = pos_w(FRAC);
    localparam int VEL_W = vel_w(FRAC);
    localparam int SUM_W = sum_w(FRAC);

    localparam logic signed [SUM_W-1:0] FLOOR_Q = SUM_W'(FLOOR_PX << FRAC);
    localparam logic signed [SUM_W-1:0] CEIL_Q  = SUM_W'(CEIL_PX << FRAC);
    localparam logic signed [SUM_W-1:0] GRAV_V  = SUM_W'(GRAVITY);
    localparam logic signed [SUM_W-1:0] MAX_V   = SUM_W'(MAX_FALL);
    localparam logic signed [SUM_W-1:0] FLAP_V  = SUM_W'(FLAP_POWER);
    localparam logic [POS_W-1:0]        START_Q = POS_W'(START_PX << FRAC);

    bird_state_t               r_state;
    logic [POS_W-1:0]          r_pos;
    logic signed [VEL_W-1:0]   r_vel;
    logic                      r_flap_q;
    logic                      r_pending;

    bird_state_t               w_nxt_state;
    logic [POS_W-1:0]          w_nxt_pos;
    logic signed [VEL_W-1:0]   w_nxt_vel;

    logic                      w_rise;
    logic                      w_flap;
    logic signed [SUM_W-1:0]   w_pos_ext;
    logic signed [SUM_W-1:0]   w_vel_ext;
    logic signed [SUM_W-1:0]   w_grav_vel;
    logic signed [SUM_W-1:0]   w_fall_vel;
    logic signed [SUM_W-1:0]   w_play_vel;
    logic signed [SUM_W-1:0]   w_play_pos;
    logic signed [SUM_W-1:0]   w_fall_pos;
    logic signed [SUM_W-1:0]   w_idle_pos;

    assign w_rise = i_flap_btn & ~r_flap_q;
    assign w_flap = r_pending | w_rise;

    // Widened signed sums so a climb past row 0 or a drop past 1023 never wraps.
    assign w_pos_ext  = $signed({{(SUM_W-POS_W){1'b0}}, r_pos});
    assign w_vel_ext  = $signed({{(SUM_W-VEL_W){r_vel[VEL_W-1]}}, r_vel});
    assign w_grav_vel = w_vel_ext + GRAV_V;
    assign w_fall_vel = (w_grav_vel > MAX_V) ? MAX_V : w_grav_vel;
    assign w_play_vel = w_flap ? FLAP_V : w_fall_vel;
    assign w_play_pos = w_pos_ext + w_play_vel;
    assign w_fall_pos = w_pos_ext + w_fall_vel;
    assign w_idle_pos = w_pos_ext + FLAP_V;

    // NOTE: every always_comb output gets a default first so no path leaves a latch.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_pos   = r_pos;
        w_nxt_vel   = r_vel;
        unique case (r_state)
            ST_IDLE: begin
                if (w_flap) begin
                    w_nxt_vel   = VEL_W'(FLAP_V);
                    w_nxt_pos   = POS_W'(w_idle_pos);
                    w_nxt_state = ST_PLAYING;
                end
            end
            ST_PLAYING: begin
                if (i_collision) begin
                    w_nxt_vel   = '0;
                    w_nxt_state = ST_FALLING;
                end else if (w_play_pos >= FLOOR_Q) begin
                    w_nxt_pos   = POS_W'(FLOOR_Q);
                    w_nxt_vel   = '0;
                    w_nxt_state = ST_DEAD;
                end else if (w_play_pos <= CEIL_Q) begin
                    w_nxt_pos   = POS_W'(CEIL_Q);
                    w_nxt_vel   = '0;
                    w_nxt_state = (CEIL_KILLS != 0) ? ST_DEAD : ST_PLAYING;
                end else begin
                    w_nxt_pos   = POS_W'(w_play_pos);
                    w_nxt_vel   = VEL_W'(w_play_vel);
                end
            end
            ST_FALLING: begin
                if (w_fall_pos >= FLOOR_Q) begin
                    w_nxt_pos   = POS_W'(FLOOR_Q);
                    w_nxt_state = ST_DEAD;
                end else begin
                    w_nxt_pos   = POS_W'(w_fall_pos);
                    w_nxt_vel   = VEL_W'(w_fall_vel);
                end
            end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all birds see pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_pos     <= START_Q;
            r_vel     <= '0;
            r_flap_q  <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_flap_q <= i_flap_btn;
            if (i_tick) begin
                r_pending <= 1'b0;
                r_state   <= w_nxt_state;
                r_pos     <= w_nxt_pos;
                r_vel     <= w_nxt_vel;
            end else if (w_rise) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign o_y     = r_pos[POS_W-1:FRAC];
    assign o_state = r_state;

endmodule

// File: rtl/bird_physics_multi.sv
// N-bird vertical physics engine: shared tick divider, per-bird channels, packed outputs.
module bird_physics_multi
    import bird_pkg::*;
#(
    parameter int NUM_BIRDS     = 2,
    parameter int Y_MIN         = 0,
    parameter int ACTIVE_HEIGHT = 480,
    parameter int SPRITE_H      = 24,
    parameter int GROUND_H      = 0,
    parameter int START_Y       = 200,
    parameter int FRAC          = 4,
    parameter int GRAVITY       = 16,
    parameter int FLAP_POWER    = -112,
    parameter int MAX_FALL      = 64,
    parameter int CEIL_KILLS    = 0,
    parameter int TICK_DIV      = 1048576
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [NUM_BIRDS-1:0]       i_flap_btn,
    input  logic [NUM_BIRDS-1:0]       i_collision,
    output logic [Y_W*NUM_BIRDS-1:0]   o_bird_y,
    output logic [NUM_BIRDS-1:0]       o_alive,
    output logic [NUM_BIRDS-1:0]       o_game_over,
    output logic                       o_all_dead,
    output logic                       o_tick
);

    localparam int CNT_W    = $clog2(TICK_DIV);
    localparam int FLOOR_PX = floor_px(Y_MIN, ACTIVE_HEIGHT, GROUND_H, SPRITE_H);

    logic [CNT_W-1:0]      r_tick_cnt;
    logic                  r_all_dead;
    logic                  w_tick;
    logic [NUM_BIRDS-1:0]  w_dead;

    assign w_tick = (r_tick_cnt == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tick_cnt <= '0;
            r_all_dead <= 1'b0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + CNT_W'(1);
            r_all_dead <= &w_dead;
        end
    end

    for (genvar g = 0; g < NUM_BIRDS; g++) begin : g_bird
        bird_state_t    w_state;
        logic [Y_W-1:0] w_y;

        bird_channel #(
            .FRAC       (FRAC),
            .GRAVITY    (GRAVITY),
            .FLAP_POWER (FLAP_POWER),
            .MAX_FALL   (MAX_FALL),
            .CEIL_KILLS (CEIL_KILLS),
            .CEIL_PX    (Y_MIN),
            .FLOOR_PX   (FLOOR_PX),
            .START_PX   (Y_MIN + START_Y)
        ) u_channel (
            .i_clk       (i_clk),
            .i_reset     (i_reset),
            .i_tick      (w_tick),
            .i_flap_btn  (i_flap_btn[g]),
            .i_collision (i_collision[g]),
            .o_y         (w_y),
            .o_state     (w_state)
        );

        assign o_bird_y[Y_W*g +: Y_W] = w_y;
        assign o_alive[g]             = (w_state == ST_PLAYING);
        assign o_game_over[g]         = (w_state == ST_FALLING) || (w_state == ST_DEAD);
        assign w_dead[g]              = (w_state == ST_DEAD);
    end

    assign o_all_dead = r_all_dead;
    assign o_tick     = w_tick;

endmodule

// File: tb/tb_bird_physics_multi.sv
// Self-checking bench: two engines (ceiling clamps / ceiling kills) driven in lock-step.
module tb_bird_physics_multi;

    localparam int FLOOR_Q = 456 * 16;
    localparam int START_Q = 200 * 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  flap_btn;
    logic [1:0]  collision;
    logic [19:0] y_a, y_b;
    logic [1:0]  alive_a, alive_b, go_a, go_b;
    logic        all_a, all_b, tick_a, tick_b;

    always #5 clk = ~clk;

    bird_physics_multi #(.NUM_BIRDS(2), .TICK_DIV(4), .CEIL_KILLS(0)) dut_a (
        .i_clk(clk), .i_reset(reset), .i_flap_btn(flap_btn), .i_collision(collision),
        .o_bird_y(y_a), .o_alive(alive_a), .o_game_over(go_a), .o_all_dead(all_a), .o_tick(tick_a)
    );

    bird_physics_multi #(.NUM_BIRDS(2), .TICK_DIV(4), .CEIL_KILLS(1)) dut_b (
        .i_clk(clk), .i_reset(reset), .i_flap_btn(flap_btn), .i_collision(collision),
        .o_bird_y(y_b), .o_alive(alive_b), .o_game_over(go_b), .o_all_dead(all_b), .o_tick(tick_b)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int y0;
        int y1;
        int alive;
        int go;
        int all_dead;
    } exp_t;

    typedef struct {
        logic [1:0] flap;
        logic [1:0] col;
        int         y0;
        int         y1;
        int         alive;
        int         go;
    } vec_t;

    exp_t sb_q[$];

    // Integer reference model, [dut][bird]; dut 1 has the killing ceiling.
    int m_st [2][2];
    int m_pos[2][2];
    int m_vel[2][2];

    function automatic void model_reset();
        for (int d = 0; d < 2; d++)
            for (int b = 0; b < 2; b++) begin
                m_st[d][b]  = 0;
                m_pos[d][b] = START_Q;
                m_vel[d][b] = 0;
            end
    endfunction

    function automatic void model_step(input logic [1:0] f, input logic [1:0] c);
        for (int d = 0; d < 2; d++)
            for (int b = 0; b < 2; b++) begin
                int v;
                int p;
                v = (m_vel[d][b] + 16 > 64) ? 64 : m_vel[d][b] + 16;
                case (m_st[d][b])
                    0: if (f[b]) begin
                        m_vel[d][b] = -112;
                        m_pos[d][b] = m_pos[d][b] - 112;
                        m_st[d][b]  = 1;
                    end
                    1: if (c[b]) begin
                        m_st[d][b]  = 2;
                        m_vel[d][b] = 0;
                    end else begin
                        if (f[b]) v = -112;
                        p = m_pos[d][b] + v;
                        if (p >= FLOOR_Q) begin
                            m_pos[d][b] = FLOOR_Q; m_vel[d][b] = 0; m_st[d][b] = 3;
                        end else if (p <= 0) begin
                            m_pos[d][b] = 0; m_vel[d][b] = 0;
                            if (d == 1) m_st[d][b] = 3;
                        end else begin
                            m_pos[d][b] = p; m_vel[d][b] = v;
                        end
                    end
                    2: begin
                        p = m_pos[d][b] + v;
                        if (p >= FLOOR_Q) begin
                            m_pos[d][b] = FLOOR_Q; m_st[d][b] = 3;
                        end else begin
                            m_pos[d][b] = p; m_vel[d][b] = v;
                        end
                    end
                    default: ;
                endcase
            end
    endfunction

    function automatic exp_t model_exp(input int d);
        exp_t e;
        e.y0       = m_pos[d][0] / 16;
        e.y1       = m_pos[d][1] / 16;
        e.alive    = ((m_st[d][1] == 1) ? 2 : 0) + ((m_st[d][0] == 1) ? 1 : 0);
        e.go       = ((m_st[d][1] >= 2) ? 2 : 0) + ((m_st[d][0] >= 2) ? 1 : 0);
        e.all_dead = (m_st[d][0] == 3 && m_st[d][1] == 3) ? 1 : 0;
        return e;
    endfunction

    function automatic bit model_all_dead();
        return m_st[0][0] == 3 && m_st[0][1] == 3;
    endfunction

    task automatic push_model();
        sb_q.push_back(model_exp(0));
        sb_q.push_back(model_exp(1));
    endtask

    task automatic compare_outputs(input string tag);
        exp_t ea, eb;
        if (sb_q.size() < 2) begin
            check({"scoreboard_empty_", tag}, sb_q.size(), 2);
            return;
        end
        ea = sb_q.pop_front();
        eb = sb_q.pop_front();
        check({"y0_a_", tag},    int'(y_a[9:0]),   ea.y0);
        check({"y1_a_", tag},    int'(y_a[19:10]), ea.y1);
        check({"alive_a_", tag}, int'(alive_a),    ea.alive);
        check({"go_a_", tag},    int'(go_a),       ea.go);
        check({"all_a_", tag},   int'(all_a),      ea.all_dead);
        check({"y0_b_", tag},    int'(y_b[9:0]),   eb.y0);
        check({"y1_b_", tag},    int'(y_b[19:10]), eb.y1);
        check({"alive_b_", tag}, int'(alive_b),    eb.alive);
        check({"go_b_", tag},    int'(go_b),       eb.go);
        check({"all_b_", tag},   int'(all_b),      eb.all_dead);
    endtask

    // Starts and ends on the negedge where the tick counter reads 1.
    task automatic do_step(input logic [1:0] f, input logic [1:0] c, input bit hold, input string tag);
        flap_btn  = f;
        collision = c;
        @(negedge clk);
        if (!hold) flap_btn = 2'b00;
        @(negedge clk);
        check({"tick_", tag}, int'(tick_a & tick_b), 1);
        @(negedge clk);
        collision = 2'b00;
        @(negedge clk);
        compare_outputs(tag);
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        reset     = 1'b1;
        flap_btn  = 2'b00;
        collision = 2'b00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        push_model();
        compare_outputs({"reset_", tag});
        check({"reset_tick_", tag}, int'(tick_a | tick_b), 0);
    endtask

    task automatic sync_to_tick(input string tag);
        int n = 0;
        while (tick_a !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        check({"tick_seen_", tag}, int'(tick_a), 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[11];
        int   p;
        string s;

        reset     = 1'b1;
        flap_btn  = 2'b00;
        collision = 2'b00;

        // Reset state and tick period
        apply_reset("init");
        sync_to_tick("init");
        p = 0;
        while (tick_a !== 1'b1 && p < 8) begin @(negedge clk); p++; end
        p = 0;
        do begin @(negedge clk); p++; end while (tick_a !== 1'b1 && p < 10);
        check("tick_period", p, 4);
        repeat (2) @(negedge clk);

        // Flap arc, then collision with simultaneous flap, then death fall
        tbl[0]  = '{2'b01, 2'b00, 193, 200, 1, 0};
        tbl[1]  = '{2'b00, 2'b00, 187, 200, 1, 0};
        tbl[2]  = '{2'b00, 2'b00, 182, 200, 1, 0};
        tbl[3]  = '{2'b00, 2'b00, 178, 200, 1, 0};
        tbl[4]  = '{2'b10, 2'b00, 175, 193, 3, 0};
        tbl[5]  = '{2'b01, 2'b01, 175, 187, 2, 1};
        tbl[6]  = '{2'b00, 2'b00, 176, 182, 2, 1};
        tbl[7]  = '{2'b01, 2'b01, 178, 178, 2, 1};
        tbl[8]  = '{2'b00, 2'b00, 181, 175, 2, 1};
        tbl[9]  = '{2'b00, 2'b00, 185, 173, 2, 1};
        tbl[10] = '{2'b00, 2'b00, 189, 172, 2, 1};
        for (int i = 0; i < 11; i++) begin
            exp_t e;
            e = '{tbl[i].y0, tbl[i].y1, tbl[i].alive, tbl[i].go, 0};
            sb_q.push_back(e);
            sb_q.push_back(e);
            model_step(tbl[i].flap, tbl[i].col);
            s.itoa(i);
            do_step(tbl[i].flap, tbl[i].col, 1'b0, {"vec", s});
        end

        // Bird0 finishes its fall, bird1 free-falls to the floor; all_dead only at the end
        for (int k = 0; k < 200 && !model_all_dead(); k++) begin
            model_step(2'b00, 2'b00);
            push_model();
            do_step(2'b00, 2'b00, 1'b0, "fall");
        end
        check("all_dead_final_a", int'(all_a), 1);
        check("floor_y0_a", int'(y_a[9:0]), 456);
        check("floor_y1_a", int'(y_a[19:10]), 456);
        for (int k = 0; k < 2; k++) begin
            model_step(2'b11, 2'b11);
            push_model();
            do_step(2'b11, 2'b11, 1'b0, "frozen");
        end

        // Reset in the middle of a death fall, mid-tick
        apply_reset("pre_fall");
        sync_to_tick("pre_fall");
        model_step(2'b01, 2'b00); push_model(); do_step(2'b01, 2'b00, 1'b0, "mf_flap");
        model_step(2'b00, 2'b01); push_model(); do_step(2'b00, 2'b01, 1'b0, "mf_hit");
        model_step(2'b00, 2'b00); push_model(); do_step(2'b00, 2'b00, 1'b0, "mf_fall");
        @(negedge clk);
        apply_reset("mid_fall");
        check("mid_fall_y0", int'(y_a[9:0]), 200);

        // Holding the flap button gives exactly one flap
        sync_to_tick("hold");
        sb_q.push_back('{193, 200, 1, 0, 0}); sb_q.push_back('{193, 200, 1, 0, 0});
        do_step(2'b01, 2'b00, 1'b1, "hold0");
        sb_q.push_back('{187, 200, 1, 0, 0}); sb_q.push_back('{187, 200, 1, 0, 0});
        do_step(2'b01, 2'b00, 1'b1, "hold1");
        sb_q.push_back('{182, 200, 1, 0, 0}); sb_q.push_back('{182, 200, 1, 0, 0});
        do_step(2'b01, 2'b00, 1'b1, "hold2");
        flap_btn = 2'b00;
        sb_q.push_back('{178, 200, 1, 0, 0}); sb_q.push_back('{178, 200, 1, 0, 0});
        do_step(2'b00, 2'b00, 1'b0, "hold_rel");

        // Repeated flaps into the ceiling; collision on the idle bird1 is ignored
        apply_reset("ceil");
        sync_to_tick("ceil");
        for (int k = 0; k < 31; k++) begin
            model_step(2'b01, 2'b10);
            push_model();
            do_step(2'b01, 2'b10, 1'b0, "ceil");
        end
        check("ceil_clamp_y0_a", int'(y_a[9:0]), 0);
        check("ceil_clamp_alive_a", int'(alive_a[0]), 1);
        check("ceil_kill_y0_b", int'(y_b[9:0]), 0);
        check("ceil_kill_go_b", int'(go_b[0]), 1);
        check("ceil_idle_bird1", int'(y_a[19:10]), 200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
